// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the byte-wide RAM port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        LS_RD = 2'd2,
        LS_WR = 2'd3
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Address presented to the RAM whenever no access is in flight.
    localparam int RAM_IDLE_ADDR = 0;

    // Number of bytes moved for a load/store size code (11 behaves as word).
    function automatic logic [2:0] size_to_len(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of RAM port, instruction-fetch port and load/store port.
// Handshake: a requester raises req with stable operands and holds it until
// it sees the one-cycle done pulse; it drops req on the edge where done is
// seen. Read data is valid in the same cycle as done.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              rdy;
    logic              rollback;
    logic [7:0]        data_read_in;
    logic [ADDR_W-1:0] addr_to_ram;
    logic [7:0]        data_write_out;
    logic              ram_read_or_write;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [31:0]       if_data;
    logic              ls_req;
    logic              ls_wr;
    logic [1:0]        ls_size;
    logic [ADDR_W-1:0] ls_addr;
    logic [31:0]       ls_wdata;
    logic              ls_done;
    logic [31:0]       ls_rdata;

    modport master (
        input  rdy, rollback, data_read_in,
        input  if_req, if_addr, ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
        output addr_to_ram, data_write_out, ram_read_or_write,
        output if_done, if_data, ls_done, ls_rdata
    );

    modport slave (
        output rdy, rollback, data_read_in,
        output if_req, if_addr, ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
        input  addr_to_ram, data_write_out, ram_read_or_write,
        input  if_done, if_data, ls_done, ls_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the byte-wide RAM between instruction fetch and load/store,
// serialising each grant into byte accesses and assembling read words.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus,
    output state_t        debug_state
);
    localparam logic [ADDR_W-1:0] IDLE_ADDR = ADDR_W'(RAM_IDLE_ADDR);

    state_t            state, state_n;
    logic              rr_ls, rr_ls_n;      // 1: LS wins when both request
    logic [2:0]        cnt, cnt_n;          // addresses issued so far
    logic [2:0]        rcnt, rcnt_n;        // read bytes captured so far
    logic [2:0]        len, len_n;          // byte count of current access
    logic              primed, primed_n;    // read data valid this cycle
    logic [31:0]       wbuf, wbuf_n;
    logic [31:0]       rbuf, rbuf_n;
    logic [31:0]       asm_word;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [7:0]        dout, dout_n;
    logic              rw, rw_n;
    logic              if_done, if_done_n;
    logic              ls_done, ls_done_n;
    logic [31:0]       if_data, if_data_n;
    logic [31:0]       ls_rdata, ls_rdata_n;
    logic              can_grant, grant_if, grant_ls, last_byte;

    // A done pulse still sits on the bus while the requester drops req, so
    // no grant is made in that cycle.
    assign can_grant = (state == IDLE) && !bus.rollback && !if_done && !ls_done;
    assign grant_ls  = can_grant && bus.ls_req && (!bus.if_req || rr_ls);
    assign grant_if  = can_grant && bus.if_req && !grant_ls;
    assign last_byte = primed && (rcnt == len - 3'd1);

    assign bus.addr_to_ram       = addr;
    assign bus.data_write_out    = dout;
    assign bus.ram_read_or_write = rw;
    assign bus.if_done           = if_done;
    assign bus.if_data           = if_data;
    assign bus.ls_done           = ls_done;
    assign bus.ls_rdata          = ls_rdata;
    assign debug_state           = state;

    // State register; rdy low freezes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (rdy_ok()) begin
            state <= state_n;
        end
    end

    function automatic logic rdy_ok();
        return bus.rdy;
    endfunction

    // Next-state: grant in IDLE, leave reads on rollback or last byte,
    // leave writes after the last byte has been driven.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (grant_ls)      state_n = bus.ls_wr ? LS_WR : LS_RD;
                else if (grant_if) state_n = IF_RD;
            end
            IF_RD, LS_RD: begin
                if (bus.rollback || last_byte) state_n = IDLE;
            end
            LS_WR: begin
                if (cnt == len) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Merge the byte arriving this cycle into the partial read word.
    always_comb begin
        asm_word = rbuf;
        asm_word[{rcnt[1:0], 3'b000} +: 8] = bus.data_read_in;
    end

    // Output/datapath next values; every output is registered below.
    always_comb begin
        addr_n     = addr;
        dout_n     = dout;
        rw_n       = rw;
        if_done_n  = 1'b0;
        ls_done_n  = 1'b0;
        if_data_n  = if_data;
        ls_rdata_n = ls_rdata;
        cnt_n      = cnt;
        rcnt_n     = rcnt;
        len_n      = len;
        primed_n   = primed;
        wbuf_n     = wbuf;
        rbuf_n     = rbuf;
        rr_ls_n    = rr_ls;
        case (state)
            IDLE: begin
                addr_n = IDLE_ADDR;
                rw_n   = 1'b0;
                dout_n = 8'h00;
                if (grant_ls || grant_if) begin
                    cnt_n    = 3'd1;
                    rcnt_n   = 3'd0;
                    primed_n = 1'b0;
                    rbuf_n   = 32'h0;
                end
                if (grant_ls) begin
                    rr_ls_n = 1'b0;
                    len_n   = size_to_len(bus.ls_size);
                    addr_n  = bus.ls_addr;
                    if (bus.ls_wr) begin
                        wbuf_n = bus.ls_wdata;
                        dout_n = bus.ls_wdata[7:0];
                        rw_n   = 1'b1;
                    end
                end else if (grant_if) begin
                    rr_ls_n = 1'b1;
                    len_n   = 3'd4;
                    addr_n  = bus.if_addr;
                end
            end
            IF_RD, LS_RD: begin
                if (bus.rollback) begin
                    addr_n   = IDLE_ADDR;
                    rbuf_n   = 32'h0;
                    primed_n = 1'b0;
                end else begin
                    primed_n = 1'b1;
                    if (cnt < len) begin
                        addr_n = addr + ADDR_W'(1);
                        cnt_n  = cnt + 3'd1;
                    end else begin
                        addr_n = IDLE_ADDR;
                    end
                    if (primed) begin
                        rbuf_n = asm_word;
                        rcnt_n = rcnt + 3'd1;
                        if (last_byte) begin
                            if (state == IF_RD) begin
                                if_done_n = 1'b1;
                                if_data_n = asm_word;
                            end else begin
                                ls_done_n  = 1'b1;
                                ls_rdata_n = asm_word;
                            end
                        end
                    end
                end
            end
            LS_WR: begin
                if (cnt < len) begin
                    addr_n = addr + ADDR_W'(1);
                    dout_n = wbuf[{cnt[1:0], 3'b000} +: 8];
                    cnt_n  = cnt + 3'd1;
                end else begin
                    addr_n    = IDLE_ADDR;
                    dout_n    = 8'h00;
                    rw_n      = 1'b0;
                    ls_done_n = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers; rdy low freezes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr     <= IDLE_ADDR;
            dout     <= 8'h00;
            rw       <= 1'b0;
            if_done  <= 1'b0;
            ls_done  <= 1'b0;
            if_data  <= 32'h0;
            ls_rdata <= 32'h0;
            cnt      <= 3'd0;
            rcnt     <= 3'd0;
            len      <= 3'd0;
            primed   <= 1'b0;
            wbuf     <= 32'h0;
            rbuf     <= 32'h0;
            rr_ls    <= 1'b1;
        end else if (bus.rdy) begin
            addr     <= addr_n;
            dout     <= dout_n;
            rw       <= rw_n;
            if_done  <= if_done_n;
            ls_done  <= ls_done_n;
            if_data  <= if_data_n;
            ls_rdata <= ls_rdata_n;
            cnt      <= cnt_n;
            rcnt     <= rcnt_n;
            len      <= len_n;
            primed   <= primed_n;
            wbuf     <= wbuf_n;
            rbuf     <= rbuf_n;
            rr_ls    <= rr_ls_n;
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the byte-wide RAM port (`data_read_in`, `addr_to_ram`, `data_write_out`, `ram_read_or_write`) and shares it between two requesters: instruction fetch (IF) and the load/store buffer (LS).
- Turns each granted request into a serial stream of byte accesses and assembles read bytes into a 32-bit result.
- Aborts speculative reads on Reorder Buffer rollback; committed stores always complete.

Parameters:
- ADDR_W, 32, address width of all address ports.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rdy  in  1  global ready; low freezes the block
- rollback  in  1  Reorder Buffer rollback request
- data_read_in  in  8  RAM read byte; valid one cycle after its address is driven on `addr_to_ram`
- addr_to_ram  out  ADDR_W  RAM byte address
- data_write_out  out  8  RAM write byte
- ram_read_or_write  out  1  0 = read, 1 = write
- if_req  in  1  fetch request; held until `if_done`
- if_addr  in  ADDR_W  fetch word address
- if_done  out  1  one-cycle pulse; `if_data` valid in the same cycle
- if_data  out  32  fetched word, little-endian
- ls_req  in  1  load/store request; held until `ls_done`
- ls_wr  in  1  1 = store, 0 = load
- ls_size  in  2  00 = byte, 01 = half, 10/11 = word
- ls_addr  in  ADDR_W  first byte address
- ls_wdata  in  32  store data, low bytes first
- ls_done  out  1  one-cycle pulse
- ls_rdata  out  32  load data, zero-extended (LS performs sign extension)

Behaviour:
- Reset (async): `addr_to_ram` = 0, `data_write_out` = 0, `ram_read_or_write` = 0, `if_done` = 0, `ls_done` = 0, `if_data` = 0, `ls_rdata` = 0, state IDLE, round-robin pointer = LS.
- rdy = 0: every register holds, `rollback` is ignored, and no new grant is made.
- All outputs are registered.
- IDLE outputs: `addr_to_ram` = 0, `ram_read_or_write` = 0.
- States: IDLE, IF_RD, LS_RD, LS_WR.
- Arbitration, evaluated in IDLE only:
  - A single requesting port wins.
  - If both request, the port named by the round-robin pointer wins.
  - The pointer flips to the other port on every grant.
- Byte count n: 4 for IF; 1, 2 or 4 for LS per `ls_size`. Byte i uses address base + i; unaligned bases are legal (plain sequential bytes).
- Counter cnt, 3 bits, counts 0..n.
- Read timing, with grant at cycle 0:
  - Byte i address is driven in cycle i+1.
  - Byte i is sampled from `data_read_in` in cycle i+2 into result bits [8i+7:8i].
  - The done pulse is in cycle n+2, with the result stable.
  - The state returns to IDLE in that same cycle.
- Write timing, with grant at cycle 0:
  - Byte i is driven in cycle i+1 with `ram_read_or_write` = 1.
  - `ls_done` pulses in cycle n+1; `ram_read_or_write` = 0 and state IDLE from that cycle.
- Requester obligation: the requester drops `req` on the edge where it sees `done`, so no re-grant occurs. Earliest next grant is the cycle after `done`.
- Unused high bytes of `ls_rdata` read as 0.
- Rollback (rdy = 1):
  - In IF_RD or LS_RD: go to IDLE next cycle, drive `addr_to_ram` = 0, no `done` pulse, and discard partial data.
  - In LS_WR: ignored; the store completes and pulses `ls_done`.
  - In IDLE: no grant in that cycle.
  - Rollback in the same cycle as a read `done` pulse: the pulse is still emitted; requesters discard it.
- Rollback never alters the round-robin pointer.
- `if_done` and `ls_done` are never high together.
- Reset mid-operation: immediate return to reset values; a partial store may leave some bytes written.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, IF_RD, LS_RD, LS_WR);
  - size encodings SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10;
  - function size_to_len(size) returning the byte count;
  - constant RAM_IDLE_ADDR = 0.
- No sub-module is natural; arbitration and byte sequencing stay in one FSM.

Test Plan:
- IF only, `if_addr` = 0x100, RAM bytes 0x13, 0x05, 0x50, 0x00 -> `addr_to_ram` 0x100..0x103 in cycles 1..4; `if_done` in cycle 6 with `if_data` = 0x00500513.
- LS store word, `ls_addr` = 0x200, `ls_wdata` = 0xDEADBEEF -> writes EF, BE, AD, DE at 0x200..0x203 in cycles 1..4 with `ram_read_or_write` = 1; `ls_done` in cycle 5.
- LS load half at 0x203 (unaligned), RAM bytes 0x34, 0x12 -> `ls_rdata` = 0x00001234, `ls_done` in cycle 4.
- `if_req` and `ls_req` both asserted, both re-requesting after each done -> grant order LS, IF, LS, IF.
- `rollback` in cycle 2 of an IF read -> IDLE in cycle 3, `addr_to_ram` = 0, no `if_done`; a later LS request is served normally.
- `rollback` in cycle 2 of a word store -> all 4 bytes written and `ls_done` in cycle 5.
- `rdy` low for cycles 2..4 of an IF read -> addresses and counter hold; `if_done` delayed by exactly 3 cycles to cycle 9.
